mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: word address width of the shared memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: memory word width, equal to the software register width.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_cmd  in  32  host command register: [0] go, [1] write(1)/read(0), [2] clear host_ovf.
- mem_addr  in  32  host address; bits [ADDR_WIDTH-1:0] used.
- mem_data_write  in  DATA_WIDTH  host write data.
- mem_data_read  out  DATA_WIDTH  host read result.
- host_busy  out  1  host request pending or in flight.
- host_done  out  1  sticky: last host access completed.
- host_ovf  out  1  sticky: go edge dropped while busy.
- proc_req  in  1  processor access request.
- proc_we  in  1  processor write(1)/read(0).
- proc_addr  in  ADDR_WIDTH  processor address.
- proc_wdata  in  DATA_WIDTH  processor write data.
- proc_gnt  out  1  one-cycle pulse: processor request accepted.
- proc_rvalid  out  1  one-cycle pulse: proc_rdata valid.
- proc_rdata  out  DATA_WIDTH  processor read data.
- ram_en  out  1  memory port enable.
- ram_we  out  1  memory port write enable.
- ram_addr  out  ADDR_WIDTH  memory address.
- ram_wdata  out  DATA_WIDTH  memory write data.
- ram_rdata  in  DATA_WIDTH  memory read data, valid the cycle after ram_en with ram_we=0.

Function
REQ-004 SHALL register go as go_d; a host request is latched (host_pend=1, plus cmd[1], addr and data captured) on the cycle with mem_cmd[0]=1 and go_d=0.
REQ-005 SHALL ignore a go edge while host_busy=1, setting host_ovf=1; host_ovf SHALL clear on a cycle with mem_cmd[2]=1, and a simultaneous new overflow takes priority (stays 1).
REQ-006 SHALL set host_done=0 on an accepted go edge and host_done=1 when that access completes.
REQ-007 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-008 In IDLE with exactly one requester (host_pend or proc_req), SHALL grant it; with both, SHALL grant the requester not granted last (last_gnt); after reset the processor wins the first tie.
REQ-009 On grant, SHALL register ram_en=1, ram_we, ram_addr and ram_wdata from the winner's operands and enter ACCESS; ram_* outputs SHALL be registered.
REQ-010 SHALL pulse proc_gnt for the ACCESS cycle of a processor grant; the processor holds req/we/addr/wdata stable until it sees proc_gnt.
REQ-011 SHALL clear host_pend in the ACCESS cycle of a host grant; host_busy SHALL stay 1 until the host access completes.
REQ-012 In ACCESS: a write SHALL return to IDLE (access complete) with ram_en=0 next cycle; a read SHALL enter RESP with ram_en=0.
REQ-013 In RESP for a processor read, SHALL drive proc_rvalid=1 and proc_rdata=ram_rdata for that cycle; proc_rdata SHALL hold its value otherwise.
REQ-014 In RESP for a host read, SHALL load mem_data_read from ram_rdata at the cycle end; mem_data_read SHALL hold otherwise, and host writes leave it unchanged.
REQ-015 SHALL return to IDLE from RESP; one access: grant to IDLE is 2 cycles (write) or 3 cycles (read); no back-to-back grant without IDLE.
REQ-016 SHALL drop a proc_req deasserted before grant with no side effect; a go edge arriving during ACCESS/RESP of a processor access is latched normally.

Reset
REQ-017 On reset=0, SHALL asynchronously force FSM=IDLE, ram_en=0, ram_we=0, proc_gnt=0, proc_rvalid=0, host_pend=0, host_busy=0, host_done=0, host_ovf=0, go_d=0, last_gnt=host, and ram_addr, ram_wdata, proc_rdata, mem_data_read to 0.
REQ-018 SHALL abort any in-flight access on reset without completing it; on release, a mem_cmd[0] already at 1 SHALL count as an edge.

Verification
REQ-019 Host write then read: mem_cmd go, write, addr 5, data 0xDEADBEEF, then go read addr 5 -> ram_we pulse at addr 5; mem_data_read=0xDEADBEEF; host_done=1.
REQ-020 Processor read of addr 3 holding 0x1234 -> proc_gnt in cycle 1 after IDLE grant, proc_rvalid with proc_rdata=0x1234 one cycle later.
REQ-021 Host and processor request in the same cycle after reset -> processor first, host next; repeat tie -> order alternates.
REQ-022 Second go edge during an active host access -> host_ovf=1, no extra ram_en; mem_cmd[2]=1 -> host_ovf=0.
REQ-023 Assert reset during ACCESS of a read -> ram_en=0 immediately, no proc_rvalid, all status bits 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of host register, processor and memory-port signals shared by the arbiter and its environment.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           mem_cmd;
    logic [31:0]           mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_write;
    logic [DATA_WIDTH-1:0] mem_data_read;
    logic                  host_busy;
    logic                  host_done;
    logic                  host_ovf;

    logic                  proc_req;
    logic                  proc_we;
    logic [ADDR_WIDTH-1:0] proc_addr;
    logic [DATA_WIDTH-1:0] proc_wdata;
    logic                  proc_gnt;
    logic                  proc_rvalid;
    logic [DATA_WIDTH-1:0] proc_rdata;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  mem_cmd, mem_addr, mem_data_write,
        input  proc_req, proc_we, proc_addr, proc_wdata,
        input  ram_rdata,
        output mem_data_read, host_busy, host_done, host_ovf,
        output proc_gnt, proc_rvalid, proc_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output mem_cmd, mem_addr, mem_data_write,
        output proc_req, proc_we, proc_addr, proc_wdata,
        output ram_rdata,
        input  mem_data_read, host_busy, host_done, host_ovf,
        input  proc_gnt, proc_rvalid, proc_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory: a software host (command register) and a processor,
// alternating on ties, one access at a time through IDLE -> ACCESS -> (RESP) -> IDLE.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic GNT_PROC = 1'b0;
    localparam logic GNT_HOST = 1'b1;

    logic [1:0]            state;
    logic                  go_d;
    logic                  host_pend;
    logic                  host_busy;
    logic                  host_done;
    logic                  host_ovf;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  last_gnt;
    logic                  owner;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  proc_gnt;
    logic                  proc_rvalid;
    logic [DATA_WIDTH-1:0] proc_rdata_q;
    logic [DATA_WIDTH-1:0] mem_data_read;

    logic go_edge;
    logic grant_host;
    logic grant_proc;
    logic host_complete;
    logic unused_bits;

    assign go_edge = bus.mem_cmd[0] & ~go_d;

    // On a tie the requester that did not win last time goes first.
    assign grant_host = host_pend & (~bus.proc_req | (last_gnt == GNT_PROC));
    assign grant_proc = bus.proc_req & (~host_pend | (last_gnt == GNT_HOST));

    assign host_complete = (owner == GNT_HOST) &&
                           (((state == ACCESS) && ram_we) || (state == RESP));

    assign unused_bits = ^{bus.mem_cmd[31:3], bus.mem_addr[31:ADDR_WIDTH]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            go_d       <= 1'b0;
            host_pend  <= 1'b0;
            host_busy  <= 1'b0;
            host_done  <= 1'b0;
            host_ovf   <= 1'b0;
            host_we    <= 1'b0;
            host_addr  <= '0;
            host_wdata <= '0;
        end else begin
            go_d <= bus.mem_cmd[0];
            if (go_edge && !host_busy) begin
                host_pend  <= 1'b1;
                host_busy  <= 1'b1;
                host_done  <= 1'b0;
                host_we    <= bus.mem_cmd[1];
                host_addr  <= bus.mem_addr[ADDR_WIDTH-1:0];
                host_wdata <= bus.mem_data_write;
            end else if ((state == IDLE) && grant_host) begin
                host_pend <= 1'b0;
            end
            if (host_complete) begin
                host_busy <= 1'b0;
                host_done <= 1'b1;
            end
            // A fresh overflow wins over a clear request in the same cycle.
            if (go_edge && host_busy) begin
                host_ovf <= 1'b1;
            end else if (bus.mem_cmd[2]) begin
                host_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_gnt      <= GNT_HOST;
            owner         <= GNT_HOST;
            ram_en        <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            proc_gnt      <= 1'b0;
            proc_rvalid   <= 1'b0;
            proc_rdata_q  <= '0;
            mem_data_read <= '0;
        end else begin
            proc_gnt    <= 1'b0;
            proc_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_host) begin
                        state     <= ACCESS;
                        owner     <= GNT_HOST;
                        last_gnt  <= GNT_HOST;
                        ram_en    <= 1'b1;
                        ram_we    <= host_we;
                        ram_addr  <= host_addr;
                        ram_wdata <= host_wdata;
                    end else if (grant_proc) begin
                        state     <= ACCESS;
                        owner     <= GNT_PROC;
                        last_gnt  <= GNT_PROC;
                        ram_en    <= 1'b1;
                        ram_we    <= bus.proc_we;
                        ram_addr  <= bus.proc_addr;
                        ram_wdata <= bus.proc_wdata;
                        proc_gnt  <= 1'b1;
                    end
                end
                ACCESS: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    if (ram_we) begin
                        state <= IDLE;
                    end else begin
                        state       <= RESP;
                        proc_rvalid <= (owner == GNT_PROC);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (owner == GNT_PROC) begin
                        proc_rdata_q <= bus.ram_rdata;
                    end else begin
                        mem_data_read <= bus.ram_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is only valid during RESP, so the processor sees it straight from the memory then.
    assign bus.proc_rdata    = proc_rvalid ? bus.ram_rdata : proc_rdata_q;
    assign bus.proc_gnt      = proc_gnt;
    assign bus.proc_rvalid   = proc_rvalid;
    assign bus.mem_data_read = mem_data_read;
    assign bus.host_busy     = host_busy;
    assign bus.host_done     = host_done;
    assign bus.host_ovf      = host_ovf;
    assign bus.ram_en        = ram_en;
    assign bus.ram_we        = ram_we;
    assign bus.ram_addr      = ram_addr;
    assign bus.ram_wdata     = ram_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: host and processor accesses against a one-cycle-latency memory model.
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mem_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [31:0] mem [0:1023];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM; address 3 is preloaded while reset is held.
    always @(posedge clk) begin
        if (!reset) begin
            mem[3] <= 32'h0000_1234;
        end else if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        bus.mem_cmd        = 32'h0;
        bus.mem_addr       = 32'h0;
        bus.mem_data_write = 32'h0;
        bus.proc_req       = 1'b0;
        bus.proc_we        = 1'b0;
        bus.proc_addr      = 10'd0;
        bus.proc_wdata     = 32'h0;
        repeat (2) @(negedge clk);
        check_bit("rst_ram_en", bus.ram_en, 1'b0);
        check_bit("rst_ram_we", bus.ram_we, 1'b0);
        check_bit("rst_busy", bus.host_busy, 1'b0);
        check_bit("rst_done", bus.host_done, 1'b0);
        check_bit("rst_ovf", bus.host_ovf, 1'b0);
        check_bit("rst_gnt", bus.proc_gnt, 1'b0);
        check_bit("rst_rvalid", bus.proc_rvalid, 1'b0);
        check_word("rst_mem_data_read", bus.mem_data_read, 32'h0);
        check_word("rst_proc_rdata", bus.proc_rdata, 32'h0);
        check_word("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        reset = 1'b1;

        $display("[TB] host write then read of addr 5");
        bus.mem_cmd        = 32'h3;
        bus.mem_addr       = 32'd5;
        bus.mem_data_write = 32'hDEAD_BEEF;
        @(negedge clk);
        check_bit("hw_latch_busy", bus.host_busy, 1'b1);
        check_bit("hw_latch_ram_en", bus.ram_en, 1'b0);
        @(negedge clk);
        check_bit("hw_grant_ram_en", bus.ram_en, 1'b1);
        check_bit("hw_grant_ram_we", bus.ram_we, 1'b1);
        check_word("hw_grant_addr", 32'(bus.ram_addr), 32'd5);
        check_word("hw_grant_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
        check_bit("hw_grant_gnt", bus.proc_gnt, 1'b0);
        @(negedge clk);
        check_bit("hw_end_ram_en", bus.ram_en, 1'b0);
        check_bit("hw_end_done", bus.host_done, 1'b1);
        check_bit("hw_end_busy", bus.host_busy, 1'b0);
        bus.mem_cmd = 32'h0;
        @(negedge clk);
        bus.mem_cmd  = 32'h1;
        bus.mem_addr = 32'd5;
        @(negedge clk);
        check_bit("hr_latch_done", bus.host_done, 1'b0);
        check_bit("hr_latch_busy", bus.host_busy, 1'b1);
        @(negedge clk);
        check_bit("hr_grant_ram_en", bus.ram_en, 1'b1);
        check_bit("hr_grant_ram_we", bus.ram_we, 1'b0);
        @(negedge clk);
        check_bit("hr_resp_ram_en", bus.ram_en, 1'b0);
        check_bit("hr_resp_rvalid", bus.proc_rvalid, 1'b0);
        check_bit("hr_resp_busy", bus.host_busy, 1'b1);
        @(negedge clk);
        check_word("hr_data", bus.mem_data_read, 32'hDEAD_BEEF);
        check_bit("hr_done", bus.host_done, 1'b1);
        check_bit("hr_busy", bus.host_busy, 1'b0);
        bus.mem_cmd = 32'h0;

        $display("[TB] processor read of addr 3");
        bus.proc_req  = 1'b1;
        bus.proc_we   = 1'b0;
        bus.proc_addr = 10'd3;
        @(negedge clk);
        check_bit("pr_gnt", bus.proc_gnt, 1'b1);
        check_bit("pr_ram_en", bus.ram_en, 1'b1);
        check_word("pr_addr", 32'(bus.ram_addr), 32'd3);
        bus.proc_req = 1'b0;
        @(negedge clk);
        check_bit("pr_rvalid", bus.proc_rvalid, 1'b1);
        check_word("pr_rdata", bus.proc_rdata, 32'h0000_1234);
        check_bit("pr_gnt_drop", bus.proc_gnt, 1'b0);
        @(negedge clk);
        check_bit("pr_rvalid_drop", bus.proc_rvalid, 1'b0);
        check_word("pr_rdata_hold", bus.proc_rdata, 32'h0000_1234);
        check_word("pr_host_data_hold", bus.mem_data_read, 32'hDEAD_BEEF);

        $display("[TB] go held through reset, then tie arbitration");
        reset              = 1'b0;
        bus.mem_cmd        = 32'h3;
        bus.mem_addr       = 32'd7;
        bus.mem_data_write = 32'hAAAA_0007;
        @(negedge clk);
        check_bit("rst2_busy", bus.host_busy, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_bit("rel_edge_busy", bus.host_busy, 1'b1);
        check_bit("rel_edge_ram_en", bus.ram_en, 1'b0);
        bus.proc_req   = 1'b1;
        bus.proc_we    = 1'b1;
        bus.proc_addr  = 10'd8;
        bus.proc_wdata = 32'hBBBB_0008;
        @(negedge clk);
        check_bit("tie1_proc_gnt", bus.proc_gnt, 1'b1);
        check_word("tie1_proc_addr", 32'(bus.ram_addr), 32'd8);
        check_bit("tie1_proc_we", bus.ram_we, 1'b1);
        bus.proc_req = 1'b0;
        @(negedge clk);
        check_bit("tie1_idle_ram_en", bus.ram_en, 1'b0);
        @(negedge clk);
        check_bit("tie1_host_ram_en", bus.ram_en, 1'b1);
        check_word("tie1_host_addr", 32'(bus.ram_addr), 32'd7);
        check_word("tie1_host_wdata", bus.ram_wdata, 32'hAAAA_0007);
        check_bit("tie1_host_gnt", bus.proc_gnt, 1'b0);
        bus.mem_cmd = 32'h0;
        @(negedge clk);
        check_bit("tie1_done", bus.host_done, 1'b1);
        bus.mem_cmd  = 32'h1;
        bus.mem_addr = 32'd8;
        @(negedge clk);
        bus.proc_req   = 1'b1;
        bus.proc_we    = 1'b1;
        bus.proc_addr  = 10'd9;
        bus.proc_wdata = 32'hCCCC_0009;
        @(negedge clk);
        check_bit("tie2_proc_gnt", bus.proc_gnt, 1'b1);
        check_word("tie2_proc_addr", 32'(bus.ram_addr), 32'd9);
        @(negedge clk);
        check_bit("tie2_idle_ram_en", bus.ram_en, 1'b0);
        @(negedge clk);
        check_bit("tie3_host_ram_en", bus.ram_en, 1'b1);
        check_word("tie3_host_addr", 32'(bus.ram_addr), 32'd8);
        check_bit("tie3_host_we", bus.ram_we, 1'b0);
        check_bit("tie3_host_gnt", bus.proc_gnt, 1'b0);
        bus.proc_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_word("tie3_read_data", bus.mem_data_read, 32'hBBBB_0008);
        check_bit("tie3_done", bus.host_done, 1'b1);
        bus.mem_cmd = 32'h0;
        @(negedge clk);

        $display("[TB] overflow on go edge while busy");
        bus.mem_cmd        = 32'h3;
        bus.mem_addr       = 32'd10;
        bus.mem_data_write = 32'h0000_0011;
        @(negedge clk);
        check_bit("ovf_latch_busy", bus.host_busy, 1'b1);
        bus.mem_cmd = 32'h0;
        @(negedge clk);
        check_bit("ovf_grant_ram_en", bus.ram_en, 1'b1);
        bus.mem_cmd = 32'h3;
        @(negedge clk);
        check_bit("ovf_set", bus.host_ovf, 1'b1);
        check_bit("ovf_busy", bus.host_busy, 1'b0);
        check_bit("ovf_ram_en", bus.ram_en, 1'b0);
        @(negedge clk);
        check_bit("ovf_no_extra_ram_en", bus.ram_en, 1'b0);
        check_bit("ovf_no_extra_busy", bus.host_busy, 1'b0);
        check_bit("ovf_sticky", bus.host_ovf, 1'b1);
        bus.mem_cmd = 32'h4;
        @(negedge clk);
        check_bit("ovf_clear", bus.host_ovf, 1'b0);
        check_word("ovf_mem_write", mem[10], 32'h0000_0011);
        bus.mem_cmd = 32'h0;

        $display("[TB] reset during ACCESS of a processor read");
        bus.proc_req  = 1'b1;
        bus.proc_we   = 1'b0;
        bus.proc_addr = 10'd3;
        @(negedge clk);
        check_bit("abort_ram_en_before", bus.ram_en, 1'b1);
        check_bit("abort_done_before", bus.host_done, 1'b1);
        reset = 1'b0;
        #1;
        check_bit("abort_ram_en", bus.ram_en, 1'b0);
        check_bit("abort_gnt", bus.proc_gnt, 1'b0);
        check_bit("abort_busy", bus.host_busy, 1'b0);
        check_bit("abort_done", bus.host_done, 1'b0);
        check_bit("abort_ovf", bus.host_ovf, 1'b0);
        check_word("abort_proc_rdata", bus.proc_rdata, 32'h0);
        @(negedge clk);
        check_bit("abort_rvalid", bus.proc_rvalid, 1'b0);
        reset        = 1'b1;
        bus.proc_req = 1'b0;
        @(negedge clk);
        check_bit("abort_after_rvalid", bus.proc_rvalid, 1'b0);
        check_bit("abort_after_ram_en", bus.ram_en, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
